// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART definitions (FSM state encodings, default oversample rate)
//   state_t        : 3-bit receiver FSM encoding shared by uart_rx and future uart_tx
//   OVERSAMPLE_DEF : oversample ticks per bit; must agree with baud_rate_gen
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input
//   clk   : destination clock
//   rst   : asynchronous active-high reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk latency)
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, 1 start / DBIT data (LSB first) / optional even parity / 1 stop
//   clk, rst   : system clock, asynchronous active-high reset
//   tick       : one-clk oversample strobe from baud_rate_gen
//   rx         : raw serial line (asynchronous, idles high)
//   rx_data    : last received byte, held until the next rx_done
//   rx_done    : one-clk pulse when a frame completes
//   frame_err  : stop bit sampled low; held with rx_data
//   parity_err : even parity mismatch; held with rx_data (0 when PARITY_EN=0)
//   busy       : high whenever the FSM is not IDLE
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PARITY_EN  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_t          state, state_n;
    logic            rx_s;
    logic [SW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] sreg;
    logic            par_ok;
    logic            at_mid, at_last, at_stop;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign at_mid  = tick && s_cnt == S_MID;
    assign at_last = tick && s_cnt == S_LAST;
    assign at_stop = tick && s_cnt == S_STOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = rx_s ? IDLE : START;
            START:     state_n = !at_mid ? START : rx_s ? IDLE : DATA;
            DATA:      state_n = !(at_last && n_cnt == N_LAST) ? DATA : PARITY_EN != 0 ? PARITY : STOP;
            PARITY:    state_n = at_last ? STOP : PARITY;
            STOP:      state_n = !at_stop ? STOP : rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
    end

    // Counters, shift register and the registered frame results. The START
    // mid-bit sample re-bases s_cnt so later samples land at bit centres.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt      <= '0;
            n_cnt      <= '0;
            sreg       <= '0;
            par_ok     <= 1'b1;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: s_cnt <= '0;
                START: if (tick) begin
                    s_cnt <= at_mid ? '0 : s_cnt + 1'b1;
                    if (at_mid) n_cnt <= '0;
                end
                DATA: if (tick) begin
                    s_cnt <= at_last ? '0 : s_cnt + 1'b1;
                    if (at_last) begin
                        sreg  <= {rx_s, sreg[DBIT-1:1]};
                        n_cnt <= n_cnt + 1'b1;
                    end
                end
                PARITY: if (tick) begin
                    s_cnt <= at_last ? '0 : s_cnt + 1'b1;
                    if (at_last) par_ok <= ~(^sreg ^ rx_s);
                end
                STOP: if (tick) begin
                    s_cnt <= at_stop ? '0 : s_cnt + 1'b1;
                    if (at_stop) begin
                        rx_data    <= sreg;
                        rx_done    <= 1'b1;
                        frame_err  <= ~rx_s;
                        parity_err <= (PARITY_EN != 0) && !par_ok;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
